// File: rtl/avalon_segx_n.sv
// rtl/avalon_segx_n.sv - N-digit seven-segment controller with an Avalon-MM register slave
// Optional scan-multiplexed outputs are enabled by defining AVALON_SEGX_SCAN_MUX_EN.
module avalon_segx_n #(
  parameter int NUM_DIGITS     = 4,
  parameter int ADDR_W         = 4,
  parameter int PRESCALE       = 50000,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int SCAN_DIV       = 1000
) (
  input  logic                    csi_clk,
  input  logic                    csi_reset_n,
  input  logic [ADDR_W-1:0]       avs_s1_address,
  input  logic                    avs_s1_read,
  input  logic                    avs_s1_write,
  input  logic [15:0]             avs_s1_writedata,
  input  logic [1:0]              avs_s1_byteenable,
  output logic [15:0]             avs_s1_readdata,
  output logic [7*NUM_DIGITS-1:0] coe_segments
`ifdef AVALON_SEGX_SCAN_MUX_EN
  ,
  output logic [6:0]              coe_scan_seg,
  output logic [NUM_DIGITS-1:0]   coe_scan_sel
`endif
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic OFF_BIT = (SEG_ACTIVE_LOW != 0);
  localparam logic [7*NUM_DIGITS-1:0] SEG_OFF = {(7*NUM_DIGITS){OFF_BIT}};

  logic                    hex_mode;
  logic                    blink_en;
  logic                    phase;
  logic [NUM_DIGITS-1:0]   blank;
  logic [NUM_DIGITS-1:0]   blink;
  logic [15:0]             blink_div;
  logic [15:0]             blink_cnt;
  logic [PW-1:0]           pre_cnt;
  logic [8*NUM_DIGITS-1:0] digit_q;

  logic [NUM_DIGITS-1:0]   lane_en;
  logic [NUM_DIGITS-1:0]   dig_sel;
  logic [8*NUM_DIGITS-1:0] dig_wmask;
  logic [ADDR_W-1:0]       dig_idx;
  logic [15:0]             rd_mux;
  logic [7*NUM_DIGITS-1:0] seg_d;
  logic                    wr_ctrl;
  logic                    wr_blank;
  logic                    wr_blink;
  logic                    wr_div;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'h3F;
      4'h1: hex7 = 7'h06;
      4'h2: hex7 = 7'h5B;
      4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;
      4'h5: hex7 = 7'h6D;
      4'h6: hex7 = 7'h7D;
      4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;
      4'h9: hex7 = 7'h6F;
      4'hA: hex7 = 7'h77;
      4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;
      4'hD: hex7 = 7'h5E;
      4'hE: hex7 = 7'h79;
      default: hex7 = 7'h71;
    endcase
  endfunction

  assign wr_ctrl  = avs_s1_write && (avs_s1_address == ADDR_W'(0));
  assign wr_blank = avs_s1_write && (avs_s1_address == ADDR_W'(1));
  assign wr_blink = avs_s1_write && (avs_s1_address == ADDR_W'(2));
  assign wr_div   = avs_s1_write && (avs_s1_address == ADDR_W'(3));
  assign dig_idx  = avs_s1_address - ADDR_W'(4);

  // Mask bits k of BLANK/BLINK belong to byte lane k/8.
  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_dec
    assign lane_en[k]          = avs_s1_byteenable[k/8];
    assign dig_sel[k]          = (avs_s1_address == ADDR_W'(4 + k));
    assign dig_wmask[8*k +: 8] = {8{avs_s1_write & dig_sel[k] & avs_s1_byteenable[0]}};
  end

  always_ff @(posedge csi_clk or negedge csi_reset_n) begin
    if (!csi_reset_n) begin
      hex_mode  <= 1'b1;
      blink_en  <= 1'b0;
      blank     <= '1;
      blink     <= '0;
      blink_div <= 16'h0000;
      digit_q   <= '0;
    end else begin
      if (wr_ctrl && avs_s1_byteenable[0]) begin
        hex_mode <= avs_s1_writedata[0];
        blink_en <= avs_s1_writedata[1];
      end
      if (wr_blank)
        blank <= (blank & ~lane_en) | (avs_s1_writedata[NUM_DIGITS-1:0] & lane_en);
      if (wr_blink)
        blink <= (blink & ~lane_en) | (avs_s1_writedata[NUM_DIGITS-1:0] & lane_en);
      if (wr_div && avs_s1_byteenable[0]) blink_div[7:0]  <= avs_s1_writedata[7:0];
      if (wr_div && avs_s1_byteenable[1]) blink_div[15:8] <= avs_s1_writedata[15:8];
      digit_q <= (digit_q & ~dig_wmask) | ({NUM_DIGITS{avs_s1_writedata[7:0]}} & dig_wmask);
    end
  end

  // Any BLINK_DIV write restarts the blink timebase from a known phase.
  always_ff @(posedge csi_clk or negedge csi_reset_n) begin
    if (!csi_reset_n) begin
      pre_cnt   <= '0;
      blink_cnt <= 16'h0000;
      phase     <= 1'b0;
    end else if (wr_div) begin
      pre_cnt   <= '0;
      blink_cnt <= 16'h0000;
      phase     <= 1'b0;
    end else if (pre_cnt == '0) begin
      pre_cnt <= PW'(PRESCALE - 1);
      if (blink_cnt == 16'h0000) begin
        blink_cnt <= blink_div;
        phase     <= ~phase;
      end else begin
        blink_cnt <= blink_cnt - 16'd1;
      end
    end else begin
      pre_cnt <= pre_cnt - PW'(1);
    end
  end

  always_comb begin
    rd_mux = 16'h0000;
    if (avs_s1_address == ADDR_W'(0))
      rd_mux = {phase, 13'b0, blink_en, hex_mode};
    else if (avs_s1_address == ADDR_W'(1))
      rd_mux[NUM_DIGITS-1:0] = blank;
    else if (avs_s1_address == ADDR_W'(2))
      rd_mux[NUM_DIGITS-1:0] = blink;
    else if (avs_s1_address == ADDR_W'(3))
      rd_mux = blink_div;
    else if (|dig_sel)
      rd_mux[7:0] = digit_q[8*dig_idx +: 8];
  end

  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_seg
    logic [6:0] pat;
    logic       off;
    assign pat = hex_mode ? hex7(digit_q[8*k +: 4]) : digit_q[8*k +: 7];
    assign off = blank[k] | (blink_en & blink[k] & phase);
    assign seg_d[7*k +: 7] = off ? {7{OFF_BIT}} : ((SEG_ACTIVE_LOW != 0) ? ~pat : pat);
  end

  always_ff @(posedge csi_clk or negedge csi_reset_n) begin
    if (!csi_reset_n) begin
      avs_s1_readdata <= 16'h0000;
      coe_segments    <= SEG_OFF;
    end else begin
      coe_segments <= seg_d;
      if (avs_s1_read) avs_s1_readdata <= rd_mux;
    end
  end

`ifdef AVALON_SEGX_SCAN_MUX_EN
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [SW-1:0] scan_cnt;
  logic [IW-1:0] scan_idx;
  logic [IW-1:0] scan_idx_nxt;

  always_comb begin
    scan_idx_nxt = scan_idx;
    if (scan_cnt == '0)
      scan_idx_nxt = (scan_idx == IW'(NUM_DIGITS - 1)) ? '0 : scan_idx + IW'(1);
  end

  // Scan segment is taken from seg_d so it always matches the coe_segments field.
  always_ff @(posedge csi_clk or negedge csi_reset_n) begin
    if (!csi_reset_n) begin
      scan_cnt     <= SW'(SCAN_DIV - 1);
      scan_idx     <= '0;
      coe_scan_sel <= NUM_DIGITS'(1);
      coe_scan_seg <= {7{OFF_BIT}};
    end else begin
      scan_cnt     <= (scan_cnt == '0) ? SW'(SCAN_DIV - 1) : scan_cnt - SW'(1);
      scan_idx     <= scan_idx_nxt;
      coe_scan_sel <= NUM_DIGITS'(1) << scan_idx_nxt;
      coe_scan_seg <= seg_d[7*scan_idx_nxt +: 7];
    end
  end
`endif

endmodule

// File: tb/tb_avalon_segx_n.sv
// tb/tb_avalon_segx_n.sv - self-checking bench for avalon_segx_n (4 digits, active-low, PRESCALE=4)
module tb_avalon_segx_n;

  localparam int ND  = 4;
  localparam int AW  = 4;
  localparam int PRE = 4;
  localparam int SD  = 3;

  logic          clk = 1'b0;
  logic          clk_run = 1'b0;
  logic          rst_n = 1'b1;
  logic [AW-1:0] address = '0;
  logic          read = 1'b0;
  logic          write = 1'b0;
  logic [15:0]   writedata = 16'h0000;
  logic [1:0]    byteenable = 2'b00;
  logic [15:0]   readdata;
  logic [27:0]   segments;
`ifdef AVALON_SEGX_SCAN_MUX_EN
  logic [6:0]    scan_seg;
  logic [3:0]    scan_sel;
`endif

  int   errors = 0;
  int   checks = 0;
  logic chk_on = 1'b0;

  always begin
    #5;
    if (clk_run) clk = ~clk;
  end

  avalon_segx_n #(
    .NUM_DIGITS(ND), .ADDR_W(AW), .PRESCALE(PRE), .SEG_ACTIVE_LOW(1), .SCAN_DIV(SD)
  ) dut (
    .csi_clk(clk),
    .csi_reset_n(rst_n),
    .avs_s1_address(address),
    .avs_s1_read(read),
    .avs_s1_write(write),
    .avs_s1_writedata(writedata),
    .avs_s1_byteenable(byteenable),
    .avs_s1_readdata(readdata),
    .coe_segments(segments)
`ifdef AVALON_SEGX_SCAN_MUX_EN
    ,
    .coe_scan_seg(scan_seg),
    .coe_scan_sel(scan_sel)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: shadow registers plus a closed-form blink phase.
  logic [6:0]  hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  logic [1:0]  m_ctrl;
  logic [3:0]  m_blank;
  logic [3:0]  m_blink;
  logic [15:0] m_div;
  logic [7:0]  m_dig [4];
  int          m_n;
  int          m_edges;
  logic [27:0] exp_seg;
  logic [15:0] exp_rd;

  // Phase toggles on the first edge after a restart, then every PRE*(div+1) edges.
  function automatic logic m_phase();
    if (m_n == 0) return 1'b0;
    return ((((m_n - 1) / (PRE * (int'(m_div) + 1))) + 1) % 2) == 1;
  endfunction

  function automatic logic [27:0] m_segs();
    logic [27:0] s;
    logic [6:0]  lit;
    s = '1;
    for (int k = 0; k < ND; k++) begin
      lit = m_ctrl[0] ? hex_tab[m_dig[k][3:0]] : m_dig[k][6:0];
      if (m_blank[k] || (m_ctrl[1] && m_blink[k] && m_phase())) s[7*k +: 7] = 7'h7F;
      else s[7*k +: 7] = ~lit;
    end
    return s;
  endfunction

  function automatic logic [15:0] m_read(input logic [3:0] a);
    case (a)
      4'd0: return {m_phase(), 13'b0, m_ctrl};
      4'd1: return {12'b0, m_blank};
      4'd2: return {12'b0, m_blink};
      4'd3: return m_div;
      4'd4, 4'd5, 4'd6, 4'd7: return {8'h00, m_dig[a - 4'd4]};
      default: return 16'h0000;
    endcase
  endfunction

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_ctrl = 2'b01; m_blank = 4'hF; m_blink = 4'h0; m_div = 16'h0000;
      for (int k = 0; k < ND; k++) m_dig[k] = 8'h00;
      m_n = 0; m_edges = 0; exp_seg = '1; exp_rd = 16'h0000;
    end else begin
      exp_seg = m_segs();
      if (read) exp_rd = m_read(address);
      if (write) begin
        case (address)
          4'd0: if (byteenable[0]) m_ctrl = writedata[1:0];
          4'd1: if (byteenable[0]) m_blank = writedata[3:0];
          4'd2: if (byteenable[0]) m_blink = writedata[3:0];
          4'd3: begin
            if (byteenable[0]) m_div[7:0]  = writedata[7:0];
            if (byteenable[1]) m_div[15:8] = writedata[15:8];
          end
          4'd4, 4'd5, 4'd6, 4'd7: if (byteenable[0]) m_dig[address - 4'd4] = writedata[7:0];
          default: ;
        endcase
      end
      m_n = (write && address == 4'd3) ? 0 : m_n + 1;
      m_edges++;
    end
  end

  initial begin
    int idx;
    forever begin
      @(negedge clk);
      if (chk_on && rst_n) begin
        check("segments", 32'(segments), 32'(exp_seg));
        check("readdata", 32'(readdata), 32'(exp_rd));
`ifdef AVALON_SEGX_SCAN_MUX_EN
        idx = (m_edges / SD) % ND;
        check("scan_sel", 32'(scan_sel), 32'(4'b0001 << idx));
        check("scan_seg", 32'(scan_seg), 32'(exp_seg[7*idx +: 7]));
`endif
      end
    end
  end

  task automatic wr(input logic [3:0] a, input logic [15:0] d, input logic [1:0] be);
    @(negedge clk);
    address = a; writedata = d; byteenable = be; write = 1'b1;
    @(negedge clk);
    write = 1'b0; byteenable = 2'b00;
  endtask

  task automatic rd(input logic [3:0] a, output logic [15:0] d);
    @(negedge clk);
    address = a; read = 1'b1;
    @(negedge clk);
    read = 1'b0;
    d = readdata;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] d;
    logic [27:0] snap;
    int          runs[$];
    int          len;
    int          bad;
    logic        cur;
    logic        prev;
    logic        seen;

    // Reset with the clock stopped must act immediately.
    #2 rst_n = 1'b0;
    #1;
    check("reset_segments_async", 32'(segments), 32'h0FFFFFFF);
    check("reset_readdata", 32'(readdata), 32'h0);
    clk_run = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk_on = 1'b1;
    rd(4'd1, d);
    check("blank_reset", 32'(d), 32'h000F);

    wr(4'd1, 16'h0000, 2'b11);
    wr(4'd4, 16'h0008, 2'b01);
    wr(4'd5, 16'h000A, 2'b01);
    @(negedge clk);
    check("hex_digit0", 32'(segments[6:0]), 32'h00);
    check("hex_digit1", 32'(segments[13:7]), 32'h08);
    check("hex_digit2", 32'(segments[20:14]), 32'h40);
    check("hex_digit3", 32'(segments[27:21]), 32'h40);

    wr(4'd0, 16'h0000, 2'b11);
    wr(4'd6, 16'h0055, 2'b01);
    @(negedge clk);
    check("raw_digit2", 32'(segments[20:14]), 32'h2A);

    wr(4'd3, 16'h1234, 2'b11);
    wr(4'd3, 16'hAB00, 2'b10);
    rd(4'd3, d);
    check("blink_div_byteenable", 32'(d), 32'hAB34);

    @(negedge clk);
    snap = segments;
    wr(4'd15, 16'hFFFF, 2'b11);
    repeat (2) @(negedge clk);
    check("unmapped_write_no_effect", 32'(segments), 32'(snap));
    rd(4'd15, d);
    check("unmapped_read", 32'(d), 32'h0000);

    wr(4'd3, 16'h0002, 2'b11);
    wr(4'd2, 16'h0001, 2'b11);
    wr(4'd0, 16'h0003, 2'b11);
    @(negedge clk);
    address = 4'd0; read = 1'b1;
    runs.delete(); len = 0; bad = 0; prev = 1'b0; seen = 1'b0;
    for (int i = 0; i < 70; i++) begin
      @(negedge clk);
      cur = (segments[6:0] == 7'h7F);
      if (readdata[15] !== cur) bad++;
      if (i > 0 && cur != prev) begin
        if (seen) runs.push_back(len);
        seen = 1'b1;
        len = 0;
      end
      len++;
      prev = cur;
    end
    read = 1'b0;
    check("phase_tracks_digit0", 32'(bad), 32'h0);
    check("blink_run_count", 32'(runs.size() >= 3), 32'h1);
    check("blink_run1_len", 32'((runs.size() > 1) ? runs[1] : 0), 32'd12);
    check("blink_run2_len", 32'((runs.size() > 2) ? runs[2] : 0), 32'd12);

    // Reset in the middle of blinking with a read in flight.
    @(negedge clk);
    address = 4'd0; read = 1'b1;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrun_reset_segments", 32'(segments), 32'h0FFFFFFF);
    check("midrun_reset_readdata", 32'(readdata), 32'h0);
    @(negedge clk);
    read = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    rd(4'd0, d);
    check("post_reset_ctrl", 32'(d[14:0]), 32'h0001);
    repeat (10) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/avalon_segx_n.md
Name: avalon_segx_n

Overview:
- Parametrised N-digit seven-segment display controller with one Avalon-MM 16-bit slave.
- Successor to the fixed two-digit segment controllers. It adds:
  - generic digit count
  - hex-decode or raw-segment mode
  - per-digit blank and blink masks with a programmable blink rate
  - selectable segment polarity
- Sits between the Avalon fabric and board segment pins. One instance replaces paired fixed-width controllers.

Parameters:
- NUM_DIGITS, 4, number of digits (1..12).
- ADDR_W, 4, slave address width. Must satisfy 2**ADDR_W >= 4+NUM_DIGITS.
- PRESCALE, 50000, clock cycles per blink tick (>=1).
- SEG_ACTIVE_LOW, 1, 1 = segment lit when output bit is 0.
- SCAN_DIV, 1000, clock cycles per scan slot (used only with SCAN_MUX_EN).

Ports:
- csi_clk  in  1  system clock.
- csi_reset_n  in  1  reset; asynchronous, active-low.
- avs_s1_address  in  ADDR_W  word address.
- avs_s1_read  in  1  read strobe.
- avs_s1_write  in  1  write strobe.
- avs_s1_writedata  in  16  write data.
- avs_s1_byteenable  in  2  lane 0 = bits 7:0, lane 1 = bits 15:8.
- avs_s1_readdata  out  16  read data, registered.
- coe_segments  out  7*NUM_DIGITS  digit k occupies bits 7k+6:7k; bit order gfedcba (bit0 = a).

Behaviour:
- Reset:
  - csi_reset_n low clears all registers asynchronously, with no clock edge needed.
  - Register reset values: CTRL=0x0001, BLANK=all ones (low NUM_DIGITS bits), BLINK=0, BLINK_DIV=0, DIGITn=0x00.
  - avs_s1_readdata=0.
  - coe_segments = all-off level: all ones if SEG_ACTIVE_LOW, else all zeros.
- Register map (word addresses):
  - 0 CTRL: bit0 hex_mode (1=decode nibble), bit1 blink_en, bit15 blink phase (read-only). Other bits read 0.
  - 1 BLANK: bit k=1 forces digit k off.
  - 2 BLINK: bit k=1 makes digit k blink.
  - 3 BLINK_DIV: 16-bit reload value.
  - 4+k DIGITk: 8-bit register; bits 15:8 read 0.
  - Unmapped addresses (including digits >= NUM_DIGITS) read 0; writes to them are ignored.
- Writes:
  - Take effect on the csi_clk edge where avs_s1_write=1.
  - Each byte lane is written only if its byteenable bit is set.
- Reads:
  - Fixed read latency of 1: readdata is valid in the cycle after avs_s1_read.
  - readdata holds its value when no read is issued.
- Read and write in the same cycle: the write is applied, and readdata returns the pre-write value.
- Blink timer:
  - Prescaler counts PRESCALE-1 down to 0 and emits a one-cycle tick at 0, then reloads.
  - On each tick the blink counter decrements. When the blink counter is 0 at a tick, it reloads BLINK_DIV and blink phase toggles.
  - Phase period is therefore (BLINK_DIV+1)*PRESCALE cycles. BLINK_DIV=0 toggles on every tick.
  - Writing BLINK_DIV clears the prescaler, the blink counter and the phase.
- Digit k off condition: BLANK[k] | (blink_en & BLINK[k] & phase).
- Digit pattern:
  - hex_mode=1: decode DIGITk[3:0] with the standard table: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71.
  - hex_mode=0: pattern = DIGITk[6:0].
- Output:
  - If SEG_ACTIVE_LOW, the pattern is inverted; an off digit drives the off level.
  - coe_segments is registered and updates on the edge after the register write, phase toggle or mode change (1-cycle latency).
- Reset asserted mid-blink or mid-transaction: everything returns to reset values immediately, and any read in flight returns 0.

Optional Feature:
- Macro: AVALON_SEGX_SCAN_MUX_EN.
- Defined:
  - Adds ports coe_scan_seg (out, 7) and coe_scan_sel (out, NUM_DIGITS, one-hot, active-high).
  - The slot counter advances every SCAN_DIV cycles; coe_scan_sel rotates digit 0 -> 1 -> ... -> NUM_DIGITS-1 -> 0.
  - coe_scan_seg carries the selected digit's final pattern, registered in the same cycle as coe_scan_sel.
  - Reset values: coe_scan_sel = 1, coe_scan_seg = off level.
  - coe_segments is unaffected.
- Not defined: these ports and their counters are absent.

Test Plan:
- Reset (NUM_DIGITS=4, SEG_ACTIVE_LOW=1): drop csi_reset_n with the clock stopped -> coe_segments = 28'hFFFFFFF at once; after release, reading BLANK gives 0x000F one cycle later.
- Hex decode: write BLANK=0, DIGIT0=0x8, DIGIT1=0xA -> digit0 field = 7'h00 and digit1 field = 7'h08 one cycle after each write; digits 2-3 show 7'h40.
- Raw mode plus byteenable:
  - CTRL=0x0000, DIGIT2=0x55 -> digit2 field = 7'h2A.
  - Write BLINK_DIV=0x1234 with be=11, then 0xAB00 with be=10 -> read back 0xAB34.
- Blink (PRESCALE=4 in bench): BLINK_DIV=2, BLINK=0x1, CTRL=0x0003 -> digit0 alternates 12 cycles off / 12 cycles on; CTRL bit15 tracks phase; other digits steady.
- Unmapped access: write 0xFFFF to address 15 -> no output change; read of address 15 returns 0x0000.
- Scan mux (macro defined, SCAN_DIV=3): coe_scan_sel steps 0001 -> 0010 -> 0100 -> 1000 -> 0001 every 3 cycles; coe_scan_seg equals the matching coe_segments field.
